// File: rtl/disp_scan_ctrl_if.sv
// rtl/disp_scan_ctrl_if.sv - producer-side frame handshake bundle for disp_scan_ctrl
//
// Purpose: carries one display frame from the system-side producer to the
// scan scheduler using a valid/ready handshake.
// Signals:
//   Dat_Valid  producer offers a frame
//   Dat_Ready  scheduler pending buffer is empty
//   Dat_In     four BCD nibbles, [3:0] = digit0 ... [15:12] = digit3
//   Dp_In      decimal point per digit, active-high
//   Bright_In  brightness 0 (1/8 duty) .. 7 (full)
//   Lzb_En     leading-zero blanking enable
// Modports: master = producer, slave = disp_scan_ctrl.

interface disp_scan_ctrl_if;
    logic        Dat_Valid;
    logic        Dat_Ready;
    logic [15:0] Dat_In;
    logic [3:0]  Dp_In;
    logic [2:0]  Bright_In;
    logic        Lzb_En;

    modport master (
        output Dat_Valid,
        output Dat_In,
        output Dp_In,
        output Bright_In,
        output Lzb_En,
        input  Dat_Ready
    );

    modport slave (
        input  Dat_Valid,
        input  Dat_In,
        input  Dp_In,
        input  Bright_In,
        input  Lzb_En,
        output Dat_Ready
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 4-digit multiplexed 7-segment scan scheduler
//
// Purpose: holds a double-buffered BCD frame (pending + active) and
// time-multiplexes one HC4511 decoder across four digit selects, with a
// blanking guard at the start of every slot, 8-step PWM brightness and
// leading-zero blanking.
// Ports:
//   Clk, Reset_N  clock, synchronous active-low reset
//   dat           frame handshake (slave side of disp_scan_ctrl_if)
//   Disp_Dat      BCD nibble to decoder A input
//   Dp            decimal point segment, active-high
//   BI_N          decoder blank, active-low
//   Sl            digit select, active-low, at most one bit low
//   Frame_Tick    one-cycle pulse in the cycle after each frame boundary

module disp_scan_ctrl #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 8
) (
    input  logic                Clk,
    input  logic                Reset_N,
    disp_scan_ctrl_if.slave     dat,
    output logic [3:0]          Disp_Dat,
    output logic                Dp,
    output logic                BI_N,
    output logic [3:0]          Sl,
    output logic                Frame_Tick
);

    localparam int              CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]   CNT_GUARD = CW'(BLANK_CYC);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;

    logic          pend_full;
    logic [15:0]   pend_dat;
    logic [3:0]    pend_dp;
    logic [2:0]    pend_bright;
    logic          pend_lzb;

    logic [15:0]   act_dat;
    logic [3:0]    act_dp;
    logic [2:0]    act_bright;
    logic          act_lzb;

    logic          boundary;
    logic          accept;
    logic [3:0]    lzb_blank;
    logic [3:0]    nib;
    logic          lit;

    assign boundary      = (idx == 2'd3) && (cnt == CNT_LAST);
    // Ready comes straight from the pending flag, so there is no
    // combinational path from Dat_Valid to Dat_Ready.
    assign accept        = dat.Dat_Valid && !pend_full;
    assign dat.Dat_Ready = !pend_full;

    // Leading-zero blanking cascades down from the most significant digit.
    assign lzb_blank[3] = act_lzb && (act_dat[15:12] == 4'd0);
    assign lzb_blank[2] = lzb_blank[3] && (act_dat[11:8] == 4'd0);
    assign lzb_blank[1] = lzb_blank[2] && (act_dat[7:4] == 4'd0);
    assign lzb_blank[0] = 1'b0;

    assign nib = act_dat[{idx, 2'b00} +: 4];

    // Lit outside the guard window, within the PWM duty, and not blanked.
    assign lit = (cnt >= CNT_GUARD) && (cnt[2:0] <= act_bright) && !lzb_blank[idx];

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Accept and transfer are mutually exclusive: accept needs pending empty,
    // transfer needs it full. A frame accepted on the boundary cycle therefore
    // waits for the next boundary instead of bypassing into active.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            pend_full   <= 1'b0;
            pend_dat    <= '0;
            pend_dp     <= '0;
            pend_bright <= '0;
            pend_lzb    <= 1'b0;
            act_dat     <= '0;
            act_dp      <= '0;
            act_bright  <= '0;
            act_lzb     <= 1'b0;
        end else begin
            if (accept) begin
                pend_full   <= 1'b1;
                pend_dat    <= dat.Dat_In;
                pend_dp     <= dat.Dp_In;
                pend_bright <= dat.Bright_In;
                pend_lzb    <= dat.Lzb_En;
            end else if (boundary && pend_full) begin
                pend_full   <= 1'b0;
                act_dat     <= pend_dat;
                act_dp      <= pend_dp;
                act_bright  <= pend_bright;
                act_lzb     <= pend_lzb;
            end
        end
    end

    // Registered slot decode: outputs lag cnt/idx by one cycle.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            Sl         <= 4'b1111;
            BI_N       <= 1'b0;
            Disp_Dat   <= 4'd0;
            Dp         <= 1'b0;
            Frame_Tick <= 1'b0;
        end else begin
            Sl         <= lit ? ~(4'b0001 << idx) : 4'b1111;
            BI_N       <= lit;
            Disp_Dat   <= nib;
            Dp         <= lit && act_dp[idx];
            Frame_Tick <= boundary;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - directed self-checking bench for disp_scan_ctrl

module tb_disp_scan_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_N;
    logic [3:0] Disp_Dat;
    logic       Dp;
    logic       BI_N;
    logic [3:0] Sl;
    logic       Frame_Tick;

    integer n_cmp = 0;
    integer n_bad = 0;

    disp_scan_ctrl_if dif ();

    disp_scan_ctrl #(.SCAN_DIV(16), .BLANK_CYC(2)) dut (
        .Clk        (Clk),
        .Reset_N    (Reset_N),
        .dat        (dif),
        .Disp_Dat   (Disp_Dat),
        .Dp         (Dp),
        .BI_N       (BI_N),
        .Sl         (Sl),
        .Frame_Tick (Frame_Tick)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dpv,
                        input logic [2:0] br, input logic lz);
        dif.Dat_In    = d;
        dif.Dp_In     = dpv;
        dif.Bright_In = br;
        dif.Lzb_En    = lz;
        dif.Dat_Valid = 1'b1;
        tick;
        dif.Dat_Valid = 1'b0;
        check("ready_after_load", 32'(dif.Dat_Ready), 32'd0);
    endtask

    task automatic wait_frame;
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (Frame_Tick) begin
                seen = 1'b1;
                break;
            end
        end
        check("frame_wait", 32'(seen), 32'd1);
    endtask

    // Called right after a Frame_Tick cycle (or reset release): each tick p
    // shows slot p/16, cnt p%16 of the frame; the last one carries Frame_Tick.
    task automatic scan_frame(input int first, input logic [63:0] lit_mask,
                              input logic [15:0] d, input logic [3:0] dpv);
        for (int p = first; p < 64; p++) begin
            int         s;
            int         c;
            logic       l;
            logic [3:0] sl_e;
            logic [10:0] e;
            logic [10:0] g;
            s    = p / 16;
            c    = p % 16;
            l    = lit_mask[p];
            sl_e = l ? ~(4'b0001 << s) : 4'b1111;
            e    = {(p == 63), sl_e, l, l & dpv[s], d[s*4 +: 4]};
            tick;
            g    = {Frame_Tick, Sl, BI_N, Dp, Disp_Dat};
            check($sformatf("scan s%0d c%0d", s, c), 32'(g), 32'(e));
        end
    endtask

    initial begin
        int n;
        Reset_N       = 1'b0;
        dif.Dat_Valid = 1'b0;
        dif.Dat_In    = '0;
        dif.Dp_In     = '0;
        dif.Bright_In = '0;
        dif.Lzb_En    = 1'b0;

        // Reset held for three cycles
        repeat (3) tick;
        check("rst_sl",    32'(Sl), 32'hF);
        check("rst_bin",   32'(BI_N), 32'd0);
        check("rst_ready", 32'(dif.Dat_Ready), 32'd1);
        check("rst_ftick", 32'(Frame_Tick), 32'd0);
        check("rst_dat",   32'(Disp_Dat), 32'd0);

        Reset_N = 1'b1;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            tick;
            if (i <= 2) check($sformatf("guard_sl_%0d", i), 32'(Sl), 32'hF);
            if (Frame_Tick) begin
                n = i;
                break;
            end
        end
        check("first_ftick_at", 32'(n), 32'd64);

        // 1234, dp on digit0, full brightness
        load(16'h1234, 4'b0001, 3'd7, 1'b0);
        wait_frame;
        check("ready_after_xfer", 32'(dif.Dat_Ready), 32'd1);
        scan_frame(0, {4{16'hFFFC}}, 16'h1234, 4'b0001);

        // Leading-zero blanking
        load(16'h0050, 4'b0000, 3'd7, 1'b1);
        wait_frame;
        scan_frame(0, {16'h0000, 16'h0000, 16'hFFFC, 16'hFFFC}, 16'h0050, 4'b0000);
        load(16'h0000, 4'b1111, 3'd7, 1'b1);
        wait_frame;
        scan_frame(0, {16'h0000, 16'h0000, 16'h0000, 16'hFFFC}, 16'h0000, 4'b0001);

        // Brightness 0: only cnt 8; brightness 3: cnt 2,3,8..11
        load(16'h1234, 4'b0000, 3'd0, 1'b0);
        wait_frame;
        scan_frame(0, {4{16'h0100}}, 16'h1234, 4'b0000);
        load(16'h1234, 4'b0000, 3'd3, 1'b0);
        wait_frame;
        scan_frame(0, {4{16'h0F0C}}, 16'h1234, 4'b0000);

        // Back-to-back frames with Dat_Valid held high
        dif.Dat_In    = 16'h1111;
        dif.Dp_In     = 4'b0000;
        dif.Bright_In = 3'd7;
        dif.Lzb_En    = 1'b0;
        dif.Dat_Valid = 1'b1;
        tick;
        check("a_ready_low", 32'(dif.Dat_Ready), 32'd0);
        dif.Dat_In = 16'h2222;
        wait_frame;
        check("a_ready_at_tick", 32'(dif.Dat_Ready), 32'd1);
        tick;
        check("b_ready_low", 32'(dif.Dat_Ready), 32'd0);
        dif.Dat_Valid = 1'b0;
        scan_frame(1, {4{16'hFFFC}}, 16'h1111, 4'b0000);
        check("b_ready_at_tick", 32'(dif.Dat_Ready), 32'd1);
        scan_frame(0, {4{16'hFFFC}}, 16'h2222, 4'b0000);

        // Reset mid-frame with a pending frame
        load(16'h9876, 4'b1111, 3'd7, 1'b0);
        repeat (35) tick;
        Reset_N = 1'b0;
        tick;
        check("mid_rst_sl",    32'(Sl), 32'hF);
        check("mid_rst_bin",   32'(BI_N), 32'd0);
        check("mid_rst_dat",   32'(Disp_Dat), 32'd0);
        check("mid_rst_dp",    32'(Dp), 32'd0);
        check("mid_rst_ftick", 32'(Frame_Tick), 32'd0);
        check("mid_rst_ready", 32'(dif.Dat_Ready), 32'd1);
        Reset_N = 1'b1;
        scan_frame(0, {4{16'h0100}}, 16'h0000, 4'b0000);
        scan_frame(0, {4{16'h0100}}, 16'h0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
